// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester, single-port data memory arbiter.
// Round-robin on ties, one access per cycle, registered outputs.
module mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_rvalid,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t state;
  logic   last_b;
  logic   a_elig;
  logic   b_elig;
  logic   pick_a;
  logic   pick_b;

  // A requester whose access is on the port this cycle sits out
  // the next decision; ties go to whoever was not granted last.
  always_comb begin
    a_elig = a_req & ~((state == ACCESS) & a_gnt);
    b_elig = b_req & ~((state == ACCESS) & b_gnt);
    pick_a = a_elig & (~b_elig | last_b);
    pick_b = b_elig & ~pick_a;
  end

  // Arbitration FSM, memory port and read-return registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last_b   <= 1'b1;
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      mem_addr <= '0;
      mem_wd   <= '0;
    end else begin
      a_rvalid <= a_gnt & mem_rd;
      b_rvalid <= b_gnt & mem_rd;
      if (a_gnt & mem_rd) a_rdata <= mem_rdata;
      if (b_gnt & mem_rd) b_rdata <= mem_rdata;
      a_gnt <= pick_a;
      b_gnt <= pick_b;
      unique case (1'b1)
        pick_a: begin
          state    <= ACCESS;
          last_b   <= 1'b0;
          mem_addr <= a_addr;
          mem_wd   <= a_wdata;
          mem_wr   <= a_we;
          mem_rd   <= ~a_we;
        end
        pick_b: begin
          state    <= ACCESS;
          last_b   <= 1'b1;
          mem_addr <= b_addr;
          mem_wd   <= b_wdata;
          mem_wr   <= b_we;
          mem_rd   <= ~b_we;
        end
        default: begin
          state  <= IDLE;
          mem_wr <= 1'b0;
          mem_rd <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table with expectation queue, plus
// hand sequences for reset and mid-access abort.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [11:0] a_addr, b_addr, mem_addr;
  logic [15:0] a_wdata, b_wdata, mem_wd, mem_rdata;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [15:0] a_rdata, b_rdata;
  logic        mem_rd, mem_wr;
  logic        mem_load;
  logic [15:0] mem [0:15];

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic ar; logic aw; logic [11:0] aa; logic [15:0] ad;
    logic br; logic bw; logic [11:0] ba; logic [15:0] bd;
    logic eag; logic ebg; logic erd; logic ewr;
    logic [11:0] ema; logic [15:0] emd;
    logic eav; logic [15:0] ead;
    logic ebv; logic [15:0] ebd;
  } vec_t;

  vec_t tbl [20];
  vec_t exp_q [$];

  mem_arbiter #(.ADDR_W(12), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt),
    .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural data memory: combinational read, write at the edge.
  assign mem_rdata = mem_rd ? mem[mem_addr[3:0]] : 16'h0;
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 16; i++) mem[i] <= 16'h5000 + 16'(i);
      mem[3] <= 16'h1004;
      mem[4] <= 16'h0008;
    end else if (mem_wr) begin
      mem[mem_addr[3:0]] <= mem_wd;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic idle_in();
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
  endtask

  initial begin
    vec_t e;
    string p;
    tbl[0]  = '{0,0,0,0,     0,0,0,'hAA, 0,0,0,0,0,0,     0,0,      0,0};
    tbl[1]  = '{1,0,3,0,     0,0,0,'hAA, 1,0,1,0,3,0,     0,0,      0,0};
    tbl[2]  = '{0,0,3,0,     0,0,0,'hAA, 0,0,0,0,3,0,     1,'h1004, 0,0};
    tbl[3]  = '{0,0,3,0,     0,0,0,'hAA, 0,0,0,0,3,0,     0,'h1004, 0,0};
    tbl[4]  = '{0,0,0,0,     1,1,8,'hAA, 0,1,0,1,8,'hAA,  0,'h1004, 0,0};
    tbl[5]  = '{0,0,0,0,     1,0,8,'hAA, 0,0,0,0,8,'hAA,  0,'h1004, 0,0};
    tbl[6]  = '{0,0,0,0,     1,0,8,'hAA, 0,1,1,0,8,'hAA,  0,'h1004, 0,0};
    tbl[7]  = '{0,0,0,0,     0,0,8,'hAA, 0,0,0,0,8,'hAA,  0,'h1004, 1,'hAA};
    tbl[8]  = '{0,0,0,0,     0,0,8,'hAA, 0,0,0,0,8,'hAA,  0,'h1004, 0,'hAA};
    tbl[9]  = '{1,0,3,0,     1,0,5,'hAA, 1,0,1,0,3,0,     0,'h1004, 0,'hAA};
    tbl[10] = '{1,0,6,0,     1,0,5,'hAA, 0,1,1,0,5,'hAA,  1,'h1004, 0,'hAA};
    tbl[11] = '{1,0,6,0,     1,0,5,'hAA, 1,0,1,0,6,0,     0,'h1004, 1,'h5005};
    tbl[12] = '{1,0,6,0,     1,0,5,'hAA, 0,1,1,0,5,'hAA,  1,'h5006, 0,'h5005};
    tbl[13] = '{0,0,6,0,     0,0,5,'hAA, 0,0,0,0,5,'hAA,  0,'h5006, 1,'h5005};
    tbl[14] = '{0,0,0,0,     0,0,5,'hAA, 0,0,0,0,5,'hAA,  0,'h5006, 0,'h5005};
    tbl[15] = '{1,0,3,0,     0,0,5,'hAA, 1,0,1,0,3,0,     0,'h5006, 0,'h5005};
    tbl[16] = '{1,0,3,0,     0,0,5,'hAA, 0,0,0,0,3,0,     1,'h1004, 0,'h5005};
    tbl[17] = '{1,0,3,0,     0,0,5,'hAA, 1,0,1,0,3,0,     0,'h1004, 0,'h5005};
    tbl[18] = '{0,0,3,0,     0,0,5,'hAA, 0,0,0,0,3,0,     1,'h1004, 0,'h5005};
    tbl[19] = '{0,0,0,0,     0,0,5,'hAA, 0,0,0,0,3,0,     0,'h1004, 0,'h5005};

    rst = 1; mem_load = 1; idle_in();
    @(posedge clk);
    @(negedge clk);
    chk("rst a_gnt", a_gnt, 0);
    chk("rst b_gnt", b_gnt, 0);
    chk("rst mem_rd", mem_rd, 0);
    chk("rst mem_wr", mem_wr, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst a_rdata", a_rdata, 0);
    chk("rst b_rdata", b_rdata, 0);
    mem_load = 0;
    rst = 0;

    for (int i = 0; i < 20; i++) begin
      a_req = tbl[i].ar; a_we = tbl[i].aw;
      a_addr = tbl[i].aa; a_wdata = tbl[i].ad;
      b_req = tbl[i].br; b_we = tbl[i].bw;
      b_addr = tbl[i].ba; b_wdata = tbl[i].bd;
      exp_q.push_back(tbl[i]);
      @(posedge clk);
      @(negedge clk);
      e = exp_q.pop_front();
      p = $sformatf("row%0d", i);
      chk({p, " a_gnt"}, a_gnt, e.eag);
      chk({p, " b_gnt"}, b_gnt, e.ebg);
      chk({p, " mem_rd"}, mem_rd, e.erd);
      chk({p, " mem_wr"}, mem_wr, e.ewr);
      chk({p, " mem_addr"}, mem_addr, e.ema);
      chk({p, " mem_wd"}, mem_wd, e.emd);
      chk({p, " a_rvalid"}, a_rvalid, e.eav);
      chk({p, " a_rdata"}, a_rdata, e.ead);
      chk({p, " b_rvalid"}, b_rvalid, e.ebv);
      chk({p, " b_rdata"}, b_rdata, e.ebd);
      chk({p, " gnt onehot"}, a_gnt & b_gnt, 0);
    end
    chk("mem[8] written", mem[8], 16'h00AA);

    // Reset pulse in the middle of a write access.
    idle_in();
    a_req = 1; a_we = 1; a_addr = 4; a_wdata = 16'hFFFF;
    @(posedge clk);
    #2;
    chk("abort pre mem_wr", mem_wr, 1);
    chk("abort pre a_gnt", a_gnt, 1);
    rst = 1;
    #1;
    chk("abort mem_wr", mem_wr, 0);
    chk("abort a_gnt", a_gnt, 0);
    chk("abort mem_addr", mem_addr, 0);
    chk("abort a_rdata", a_rdata, 0);
    @(negedge clk);
    idle_in();
    @(posedge clk);
    @(negedge clk);
    chk("abort mem[4]", mem[4], 16'h0008);
    chk("abort a_rvalid", a_rvalid, 0);
    rst = 0;

    // First tie after reset goes to A; then read back addr 4.
    a_req = 1; a_addr = 4; b_req = 1; b_addr = 7;
    @(posedge clk);
    @(negedge clk);
    chk("tie a_gnt", a_gnt, 1);
    chk("tie b_gnt", b_gnt, 0);
    chk("tie mem_addr", mem_addr, 4);
    a_req = 0;
    @(posedge clk);
    @(negedge clk);
    chk("tie2 b_gnt", b_gnt, 1);
    chk("tie2 a_rvalid", a_rvalid, 1);
    chk("tie2 a_rdata", a_rdata, 16'h0008);
    b_req = 0;
    @(posedge clk);
    @(negedge clk);
    chk("tie3 b_rdata", b_rdata, 16'h5007);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
